// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side signals of the IF/ID boundary, bundled for port use.
// master drives fetch/control inputs and observes the ID bundle; slave is the buffer.
interface if_id_buffer_if;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic        if_misaligned;
   logic        if_fire;
   logic        if_ready;
   logic [31:0] i_in;
   logic        stall;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [31:0] id_ir;
   logic        id_misaligned;

   modport master (
      output if_pc, if_pc4, if_misaligned, if_fire, i_in, stall, flush,
      input  if_ready, id_valid, id_pc, id_pc4, id_ir, id_misaligned
   );

   modport slave (
      input  if_pc, if_pc4, if_misaligned, if_fire, i_in, stall, flush,
      output if_ready, id_valid, id_pc, id_pc4, id_ir, id_misaligned
   );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID boundary: pairs each issued PC with the Imem word returning one cycle later,
// with a one-entry skid (A slot) in front of the registered decode bundle (D slot).
module if_id_buffer #(
   parameter logic [31:0] NOP_INSN = 32'h0000_0013,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   if_id_buffer_if.slave  bus
);

   logic        a_valid_q, a_valid_d;
   logic [31:0] a_pc_q, a_pc_d;
   logic [31:0] a_pc4_q, a_pc4_d;
   logic        a_mis_q, a_mis_d;
   logic [31:0] a_ir_q, a_ir_d;
   logic        a_ir_held_q, a_ir_held_d;

   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] id_ir_q, id_ir_d;
   logic        id_mis_q, id_mis_d;

   logic        d_adv;
   logic        if_ready;
   logic        accept;
   logic [31:0] a_word;

   always_comb begin
      d_adv    = ~bus.stall | ~id_valid_q;
      // A flush frees the A slot, so the redirect target can always be taken.
      if_ready = bus.flush | ~(a_valid_q & ~d_adv);
      accept   = bus.if_fire & if_ready;
      a_word   = a_ir_held_q ? a_ir_q : bus.i_in;

      a_valid_d   = a_valid_q;
      a_pc_d      = a_pc_q;
      a_pc4_d     = a_pc4_q;
      a_mis_d     = a_mis_q;
      a_ir_d      = a_ir_q;
      a_ir_held_d = a_ir_held_q;
      id_valid_d  = id_valid_q;
      id_pc_d     = id_pc_q;
      id_pc4_d    = id_pc4_q;
      id_ir_d     = id_ir_q;
      id_mis_d    = id_mis_q;

      if (bus.flush) begin
         a_valid_d   = 1'b0;
         a_ir_held_d = 1'b0;
         id_valid_d  = 1'b0;
         id_ir_d     = NOP_INSN;
         id_mis_d    = 1'b0;
      end else if (d_adv) begin
         if (a_valid_q) begin
            id_valid_d = 1'b1;
            id_pc_d    = a_pc_q;
            id_pc4_d   = a_pc4_q;
            id_ir_d    = a_mis_q ? NOP_INSN : a_word;
            id_mis_d   = a_mis_q;
         end else begin
            id_valid_d = 1'b0;
            id_ir_d    = NOP_INSN;
            id_mis_d   = 1'b0;
         end
         a_valid_d = 1'b0;
      end else if (a_valid_q && !a_ir_held_q) begin
         // i_in is only valid in A's first cycle; park it before it disappears.
         a_ir_d      = bus.i_in;
         a_ir_held_d = 1'b1;
      end

      if (accept) begin
         a_valid_d   = 1'b1;
         a_pc_d      = bus.if_pc;
         a_pc4_d     = bus.if_pc4;
         a_mis_d     = bus.if_misaligned;
         a_ir_held_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_q   <= 1'b0;
         a_pc_q      <= RESET_PC;
         a_pc4_q     <= RESET_PC;
         a_mis_q     <= 1'b0;
         a_ir_q      <= NOP_INSN;
         a_ir_held_q <= 1'b0;
         id_valid_q  <= 1'b0;
         id_pc_q     <= RESET_PC;
         id_pc4_q    <= RESET_PC;
         id_ir_q     <= NOP_INSN;
         id_mis_q    <= 1'b0;
      end else begin
         a_valid_q   <= a_valid_d;
         a_pc_q      <= a_pc_d;
         a_pc4_q     <= a_pc4_d;
         a_mis_q     <= a_mis_d;
         a_ir_q      <= a_ir_d;
         a_ir_held_q <= a_ir_held_d;
         id_valid_q  <= id_valid_d;
         id_pc_q     <= id_pc_d;
         id_pc4_q    <= id_pc4_d;
         id_ir_q     <= id_ir_d;
         id_mis_q    <= id_mis_d;
      end
   end

   assign bus.if_ready      = if_ready;
   assign bus.id_valid      = id_valid_q;
   assign bus.id_pc         = id_pc_q;
   assign bus.id_pc4        = id_pc4_q;
   assign bus.id_ir         = id_ir_q;
   assign bus.id_misaligned = id_mis_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: scenario tasks push expected bundles; a negedge monitor
// pops one each time ID consumes a valid bundle and checks bubbles carry the NOP.
module tb_if_id_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] ir;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t e;

   if_id_buffer_if bus ();

   if_id_buffer #(.NOP_INSN(NOP), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      bus.if_fire       = 1'b0;
      bus.if_pc         = '0;
      bus.if_pc4        = 32'd4;
      bus.if_misaligned = 1'b0;
      bus.i_in          = '0;
      bus.stall         = 1'b0;
      bus.flush         = 1'b0;
   end

   // Scoreboard: a bundle is consumed when valid and ID is not stalled.
   always @(negedge clk) begin
      if (!rst && !bus.flush) begin
         if (bus.id_valid && !bus.stall) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_bundle: got pc=%h ir=%h, none expected", bus.id_pc, bus.id_ir);
            end else begin
               e = sb.pop_front();
               if ({bus.id_pc, bus.id_pc4, bus.id_ir, bus.id_misaligned} !== {e.pc, e.pc4, e.ir, e.mis}) begin
                  n_err++;
                  $display("FAIL bundle: got pc=%h pc4=%h ir=%h mis=%b, expected pc=%h pc4=%h ir=%h mis=%b",
                           bus.id_pc, bus.id_pc4, bus.id_ir, bus.id_misaligned, e.pc, e.pc4, e.ir, e.mis);
               end
            end
         end else if (!bus.id_valid) begin
            n_vec++;
            if (bus.id_ir !== NOP) begin
               n_err++;
               $display("FAIL bubble_ir: got %h, expected %h", bus.id_ir, NOP);
            end
         end
      end
   end

   // Applies one cycle of inputs just after a rising edge, returns at the following negedge.
   task automatic drive(input logic fire, input logic [31:0] pc, input logic mis,
                        input logic [31:0] word, input logic st, input logic fl, input logic rs);
      @(posedge clk);
      #1;
      bus.if_fire       = fire;
      bus.if_pc         = pc;
      bus.if_pc4        = pc + 32'd4;
      bus.if_misaligned = mis;
      bus.i_in          = word;
      bus.stall         = st;
      bus.flush         = fl;
      rst               = rs;
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] word, input logic mis);
      exp_t x;
      x.pc  = pc;
      x.pc4 = pc + 32'd4;
      x.ir  = mis ? NOP : word;
      x.mis = mis;
      sb.push_back(x);
   endtask

   task automatic test_reset;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if ({bus.id_valid, bus.id_ir, bus.id_pc, bus.id_pc4, bus.id_misaligned, bus.if_ready}
          !== {1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b ir=%h pc=%h pc4=%h mis=%b rdy=%b, expected 0/%h/0/0/0/1",
                  bus.id_valid, bus.id_ir, bus.id_pc, bus.id_pc4, bus.id_misaligned, bus.if_ready, NOP);
      end
   endtask

   task automatic test_streaming;
      drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      push_exp(32'h0, 32'hA, 1'b0);
      drive(1'b1, 32'h4, 1'b0, 32'hA, 1'b0, 1'b0, 1'b0);
      push_exp(32'h4, 32'hB, 1'b0);
      n_vec++;
      if (bus.id_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stream_latency1: got id_valid=%b, expected 0", bus.id_valid);
      end
      drive(1'b1, 32'h8, 1'b0, 32'hB, 1'b0, 1'b0, 1'b0);
      push_exp(32'h8, 32'hC, 1'b0);
      n_vec++;
      if ({bus.id_valid, bus.id_pc} !== {1'b1, 32'h0}) begin
         n_err++;
         $display("FAIL stream_latency2: got valid=%b pc=%h, expected 1/00000000", bus.id_valid, bus.id_pc);
      end
      drive(1'b0, 32'h0, 1'b0, 32'hC, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({bus.id_valid, bus.id_ir} !== {1'b0, NOP}) begin
         n_err++;
         $display("FAIL stream_bubble: got valid=%b ir=%h, expected 0/%h", bus.id_valid, bus.id_ir, NOP);
      end
   endtask

   task automatic test_stall_skid;
      drive(1'b1, 32'hC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      push_exp(32'hC, 32'h0010_0093, 1'b0);
      drive(1'b1, 32'h10, 1'b0, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
      push_exp(32'h10, 32'h0050_0093, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0050_0093, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (bus.if_ready !== 1'b0) begin
         n_err++;
         $display("FAIL skid_ready0: got if_ready=%b, expected 0", bus.if_ready);
      end
      // Fire while not ready: must be ignored.
      drive(1'b1, 32'h99, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (bus.if_ready !== 1'b0) begin
         n_err++;
         $display("FAIL skid_ready1: got if_ready=%b, expected 0", bus.if_ready);
      end
      drive(1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ({bus.id_valid, bus.id_pc} !== {1'b1, 32'hC}) begin
         n_err++;
         $display("FAIL skid_hold: got valid=%b pc=%h, expected 1/0000000c", bus.id_valid, bus.id_pc);
      end
      drive(1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (bus.if_ready !== 1'b1) begin
         n_err++;
         $display("FAIL skid_release_ready: got if_ready=%b, expected 1", bus.if_ready);
      end
      drive(1'b0, 32'h0, 1'b0, 32'hEEEE_EEEE, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({bus.id_pc, bus.id_ir} !== {32'h10, 32'h0050_0093}) begin
         n_err++;
         $display("FAIL skid_release: got pc=%h ir=%h, expected 00000010/00500093", bus.id_pc, bus.id_ir);
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++)
         drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL skid_drain: got %0d pending, expected 0", sb.size());
      end
   endtask

   task automatic test_flush;
      drive(1'b1, 32'h20, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h24, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h40, 1'b0, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
      push_exp(32'h40, 32'h0400_0413, 1'b0);
      n_vec++;
      if (bus.if_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_ready: got if_ready=%b, expected 1", bus.if_ready);
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0400_0413, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({bus.id_valid, bus.id_ir, bus.id_misaligned} !== {1'b0, NOP, 1'b0}) begin
         n_err++;
         $display("FAIL flush_squash: got valid=%b ir=%h mis=%b, expected 0/%h/0",
                  bus.id_valid, bus.id_ir, bus.id_misaligned, NOP);
      end
      drive(1'b0, 32'h0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({bus.id_valid, bus.id_pc, bus.id_ir} !== {1'b1, 32'h40, 32'h0400_0413}) begin
         n_err++;
         $display("FAIL flush_target: got valid=%b pc=%h ir=%h, expected 1/00000040/04000413",
                  bus.id_valid, bus.id_pc, bus.id_ir);
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++)
         drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL flush_drain: got %0d pending, expected 0", sb.size());
      end
   endtask

   task automatic test_misaligned;
      drive(1'b1, 32'h6, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      push_exp(32'h6, 32'hDEAD_BEEF, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({bus.id_valid, bus.id_pc, bus.id_misaligned, bus.id_ir} !== {1'b1, 32'h6, 1'b1, NOP}) begin
         n_err++;
         $display("FAIL misaligned: got valid=%b pc=%h mis=%b ir=%h, expected 1/00000006/1/%h",
                  bus.id_valid, bus.id_pc, bus.id_misaligned, bus.id_ir, NOP);
      end
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_stall;
      drive(1'b1, 32'h4C, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h50, 1'b0, 32'h4C4C_4C4C, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h5050_5050, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({bus.id_valid, bus.id_ir, bus.id_pc, bus.id_pc4, bus.id_misaligned, bus.if_ready}
          !== {1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_mid_stall: got valid=%b ir=%h pc=%h pc4=%h mis=%b rdy=%b, expected 0/%h/0/0/0/1",
                  bus.id_valid, bus.id_ir, bus.id_pc, bus.id_pc4, bus.id_misaligned, bus.if_ready, NOP);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         n_vec++;
         if (bus.id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_lost_word: got id_valid=%b pc=%h, expected 0", bus.id_valid, bus.id_pc);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic        fire, mis, st, pend;
      logic [31:0] pc, w, pend_word;
      pc   = 32'h100;
      pend = 1'b0;
      pend_word = '0;
      for (int i = 0; i < 80; i++) begin
         fire = ($urandom_range(3) != 0);
         st   = ($urandom_range(2) == 0);
         mis  = ($urandom_range(7) == 0);
         drive(fire, pc, mis, pend ? pend_word : $urandom, st, 1'b0, 1'b0);
         if (fire && bus.if_ready) begin
            w = $urandom;
            push_exp(pc, w, mis);
            pend      = 1'b1;
            pend_word = w;
            pc        = pc + 32'd4;
         end else begin
            pend = 1'b0;
         end
      end
      drive(1'b0, 32'h0, 1'b0, pend ? pend_word : 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10 && sb.size() > 0; i++)
         drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall_skid();
      test_flush();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_stall();
      n_vec++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL final_queue: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
